crc_tx_sel: RTL
===============

Name: crc_tx_sel

Overview:
- Registered, handshaked successor to the combinational CRC5/CRC16 output mux in the USB token/data packet path.
- On a load strobe, captures the CRC chosen by a one-hot select and holds the legacy parallel outputs.
- Serialises the captured CRC one bit per accepted beat toward the bit-stuffer/NRZI stage, with optional inversion and sticky illegal-select reporting.

Parameters:
- W5, 5, width of short CRC (token CRC5).
- W16, 16, width of long CRC (data CRC16).
- INVERT, 1, 1 = complement captured CRC before serialising (USB residual rule); 0 = send as-is.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- crc5_i  in  W5  short CRC from CRC5 engine
- crc16_i  in  W16  long CRC from CRC16 engine
- sel  in  3  one-hot: 001 = CRC5, 010 = CRC16, 100 = no CRC (handshake packet)
- load  in  1  single-cycle capture strobe; sel, crc5_i, crc16_i sampled here
- crc5_o  out  W5  registered parallel CRC5 (legacy view), 0 unless CRC5 selected
- crc16_o  out  W16  registered parallel CRC16 (legacy view), 0 unless CRC16 selected
- bit_o  out  1  serial CRC bit
- bit_vld_o  out  1  bit_o valid
- bit_rdy_i  in  1  downstream accepts bit_o
- last_o  out  1  high with final serial bit
- busy_o  out  1  high in SHIFT
- done_o  out  1  one-cycle pulse when a load completes (including the no-CRC case)
- err_o  out  1  sticky illegal-select / overrun flag, cleared by next legal load in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; shift register and bit counter 0.
- States:
  - IDLE: accepts load.
  - SHIFT: serialising; bit_vld_o=1.
- Load in IDLE, sel=001:
  - Next edge: crc5_o <= crc5_i, crc16_o <= 0.
  - shreg <= INVERT ? ~crc5_i : crc5_i, zero-extended to W16.
  - cnt <= W5; state -> SHIFT; err_o <= 0.
- Load in IDLE, sel=010:
  - Same as 001, using crc16_i, W16, crc5_o <= 0.
- Load in IDLE, sel=100:
  - Both parallel outputs <= 0; no SHIFT; done_o pulses on the next cycle; err_o <= 0.
- Load in IDLE, any other sel (000, multi-hot):
  - Parallel outputs hold their previous values; err_o <= 1; stay in IDLE; no done_o.
- SHIFT output:
  - bit_o = shreg[0] (LSB-first); last_o = (cnt==1).
- Beat (bit_vld_o & bit_rdy_i):
  - shreg shifts right with zero fill; cnt decrements.
  - On the beat with cnt==1: state -> IDLE, bit_vld_o=0 next cycle, done_o pulses next cycle.
- bit_rdy_i low:
  - bit_o, last_o and cnt hold; no timeout.
- Load during SHIFT:
  - Ignored; shreg and parallel outputs unchanged; err_o <= 1.
- Load on the cycle after the final beat (state IDLE):
  - Accepted normally; done_o and the new capture may coincide.
- Latency:
  - Load -> first bit_vld_o: 1 cycle.
  - Load -> done_o: W+1 cycles with bit_rdy_i held high; 1 cycle for the no-CRC case.
- Input sampling:
  - crc5_i/crc16_i changes outside the load cycle have no effect.
- Reset mid-SHIFT:
  - Immediate return to reset values; no done_o.

Optional Feature:
- CRC_TX_MSB_FIRST_EN defined:
  - bit_o = shreg[W-1] of the active width.
  - Left shift with zero fill; the captured value is right-aligned per width, so the CRC5 MSB sits at index W5-1.
- Not defined:
  - LSB-first only, as above.
- Parallel outputs and handshake are identical in both builds.

Test Plan:
- CRC5, INVERT=1, crc5_i=5'b10110, sel=001, load, bit_rdy_i=1:
  - crc5_o=5'b10110, crc16_o=0.
  - bit_o sequence 1,0,0,1,0; last_o on 5th beat.
  - done_o pulse 6 cycles after load.
- CRC16, crc16_i=16'hA55A, sel=010, bit_rdy_i toggled 1/0:
  - crc16_o=16'hA55A.
  - 16 accepted bits forming 16'h5AA5 LSB-first (first four: 1,0,1,0).
  - Holds stable while rdy=0.
- sel=100 with load:
  - Both parallel outputs 0; bit_vld_o never asserted; done_o 1 cycle after load.
- sel=011, then sel=000, each with load:
  - err_o=1 and stays in IDLE.
  - A subsequent legal load clears err_o and serialises normally.
- Load with sel=010 issued mid-CRC5 shift:
  - CRC5 stream completes unchanged; err_o=1; crc16_o not updated.
- rst_n pulled low at beat 3 of a CRC16 shift:
  - All outputs 0 immediately; no done_o.
  - A new load after release serialises from bit 0.

Source files
------------

// File: rtl/crc_tx_sel.sv
// rtl/crc_tx_sel.sv - registered CRC5/CRC16 capture and bit serialiser for the USB packet path
// Optional build macro: CRC_TX_MSB_FIRST_EN (MSB-first serialisation; LSB-first when undefined)
module crc_tx_sel #(
  parameter int W5     = 5,
  parameter int W16    = 16,
  parameter bit INVERT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W5-1:0]  crc5_i,
  input  logic [W16-1:0] crc16_i,
  input  logic [2:0]     sel,
  input  logic           load,
  output logic [W5-1:0]  crc5_o,
  output logic [W16-1:0] crc16_o,
  output logic           bit_o,
  output logic           bit_vld_o,
  input  logic           bit_rdy_i,
  output logic           last_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  localparam int CW = $clog2(W16 + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [W16-1:0] shreg;
  logic [CW-1:0]  cnt;
  logic           cap5, cap16, nocrc, illegal, fin, beat;
`ifdef CRC_TX_MSB_FIRST_EN
  logic           wide;
`endif

  assign beat = (state == SHIFT) && bit_rdy_i;

  always_comb begin
    state_nxt = state;
    cap5      = 1'b0;
    cap16     = 1'b0;
    nocrc     = 1'b0;
    illegal   = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          case (sel)
            3'b001: begin
              cap5      = 1'b1;
              state_nxt = SHIFT;
            end
            3'b010: begin
              cap16     = 1'b1;
              state_nxt = SHIFT;
            end
            3'b100:  nocrc   = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        // a load while serialising is an overrun: dropped and flagged
        illegal = load;
        if (beat && (cnt == CW'(1))) begin
          fin       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      crc5_o  <= '0;
      crc16_o <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
`ifdef CRC_TX_MSB_FIRST_EN
      wide    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      done_o <= fin | nocrc;

      if (cap5 || cap16 || nocrc)
        err_o <= 1'b0;
      else if (illegal)
        err_o <= 1'b1;

      if (cap5) begin
        crc5_o  <= crc5_i;
        crc16_o <= '0;
        shreg   <= W16'(crc5_i ^ {W5{INVERT}});
        cnt     <= CW'(W5);
`ifdef CRC_TX_MSB_FIRST_EN
        wide    <= 1'b0;
`endif
      end else if (cap16) begin
        crc5_o  <= '0;
        crc16_o <= crc16_i;
        shreg   <= crc16_i ^ {W16{INVERT}};
        cnt     <= CW'(W16);
`ifdef CRC_TX_MSB_FIRST_EN
        wide    <= 1'b1;
`endif
      end else if (nocrc) begin
        crc5_o  <= '0;
        crc16_o <= '0;
      end else if (beat) begin
`ifdef CRC_TX_MSB_FIRST_EN
        shreg <= {shreg[W16-2:0], 1'b0};
`else
        shreg <= {1'b0, shreg[W16-1:1]};
`endif
        cnt   <= cnt - CW'(1);
      end
    end
  end

  assign busy_o    = (state == SHIFT);
  assign bit_vld_o = busy_o;
  assign last_o    = busy_o && (cnt == CW'(1));
`ifdef CRC_TX_MSB_FIRST_EN
  // CRC5 stays right-aligned, so its MSB is read from index W5-1
  assign bit_o     = busy_o && (wide ? shreg[W16-1] : shreg[W5-1]);
`else
  assign bit_o     = busy_o && shreg[0];
`endif

endmodule
